// File: rtl/minicpu_pkg.sv
// minicpu_pkg: shared nibble type and ld write-select bit positions
package minicpu_pkg;
  localparam int NIBBLE_W = 4;
  typedef logic [NIBBLE_W-1:0] nibble_t;
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;
endpackage

// File: rtl/nibble_reg.sv
// nibble_reg: WIDTH-bit register with async active-low clear and load enable
//   clk, rst_n : clock, async active-low clear
//   en, d      : load enable and data
//   q          : registered value
module nibble_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (en) r_q <= d;
  assign q = r_q;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: minicpu register bank (A, B, output port, PC, carry, ld error)
//   clk, rst_n         : clock, async active-low reset
//   step               : instruction-cycle enable
//   alu_out, alu_c     : ALU sum and carry to write back
//   ld                 : one-hot write select [A,B,OUT,PC]
//   a, b, port_out, pc : registered state
//   cflag, ld_err      : latched carry, sticky illegal-ld flag
module reg_bank
  import minicpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  input  logic [3:0]       ld,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] pc,
  output logic             cflag,
  output logic             ld_err
);
  logic [WIDTH-1:0] r_pc;
  logic             r_cflag;
  logic             r_ld_err;
  logic             w_legal;
  logic             w_wr;
  // clearing the lowest set bit leaves zero only for zero or one-hot patterns
  assign w_legal = ~|(ld & (ld - 4'd1));
  assign w_wr    = step & w_legal;
  nibble_reg #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .rst_n(rst_n), .en(w_wr & ld[LD_A]), .d(alu_out), .q(a)
  );
  nibble_reg #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .rst_n(rst_n), .en(w_wr & ld[LD_B]), .d(alu_out), .q(b)
  );
  nibble_reg #(.WIDTH(WIDTH)) u_out (
    .clk(clk), .rst_n(rst_n), .en(w_wr & ld[LD_OUT]), .d(alu_out), .q(port_out)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc     <= '0;
      r_cflag  <= 1'b0;
      r_ld_err <= 1'b0;
    end else if (step) begin
      r_pc     <= (w_legal & ld[LD_PC]) ? alu_out : r_pc + WIDTH'(1);
      r_cflag  <= alu_c;
      r_ld_err <= r_ld_err | ~w_legal;
    end
  assign pc     = r_pc;
  assign cflag  = r_cflag;
  assign ld_err = r_ld_err;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed stimulus, behavioural model and per-cycle compare for reg_bank
module tb_reg_bank;
  import minicpu_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       step;
  nibble_t    alu_out;
  logic       alu_c;
  logic [3:0] ld;
  nibble_t    a, b, port_out, pc;
  logic       cflag, ld_err;
  nibble_t    m_a, m_b, m_out, m_pc;
  logic       m_c, m_err;
  logic       chk_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  reg_bank #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .alu_out(alu_out), .alu_c(alu_c), .ld(ld),
    .a(a), .b(b), .port_out(port_out), .pc(pc), .cflag(cflag), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  // model: a legal ld has at most one bit set; an illegal one writes nothing and jumps nowhere
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_a <= 0; m_b <= 0; m_out <= 0; m_pc <= 0; m_c <= 0; m_err <= 0;
    end else if (step) begin
      m_c <= alu_c;
      if ($countones(ld) > 1) begin
        m_err <= 1'b1;
        m_pc  <= m_pc + 4'd1;
      end else begin
        if (ld == 4'b0001) m_a <= alu_out;
        if (ld == 4'b0010) m_b <= alu_out;
        if (ld == 4'b0100) m_out <= alu_out;
        m_pc <= (ld == 4'b1000) ? alu_out : m_pc + 4'd1;
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      n_tests++;
      if ({a, b, port_out, pc, cflag, ld_err} !== {m_a, m_b, m_out, m_pc, m_c, m_err}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got a=%h b=%h out=%h pc=%h c=%b err=%b, model a=%h b=%h out=%h pc=%h c=%b err=%b",
                 $time, a, b, port_out, pc, cflag, ld_err, m_a, m_b, m_out, m_pc, m_c, m_err);
      end
    end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input nibble_t ea, input nibble_t eb, input nibble_t eo,
                         input nibble_t ep, input logic ec, input logic ee);
    chk({name, ".a"}, a, ea);
    chk({name, ".b"}, b, eb);
    chk({name, ".out"}, port_out, eo);
    chk({name, ".pc"}, pc, ep);
    chk({name, ".c"}, {3'b0, cflag}, {3'b0, ec});
    chk({name, ".err"}, {3'b0, ld_err}, {3'b0, ee});
  endtask

  task automatic cyc(input logic s, input logic [3:0] l, input nibble_t d, input logic c);
    step = s; ld = l; alu_out = d; alu_c = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #2;
    chk_all("rst_pulse", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; ld = 4'b0; alu_out = 4'h0; alu_c = 1'b0;
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1, 4'b0001, 4'h5, 0);
    chk_all("write_a", 4'h5, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0);
    cyc(1, 4'b0100, 4'hF, 1);
    chk_all("write_out", 4'h5, 4'h0, 4'hF, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, (i == 0) ? 4'b0011 : 4'b1001, 4'h3, i[0]);
    chk_all("hold", 4'h5, 4'h0, 4'hF, 4'h2, 1'b1, 1'b0);
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 4'b0000, 4'(i), i[0]);
      chk("pc_wrap", pc, 4'(i + 1));
    end
    chk_all("wrap_end", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    pulse_reset();
    cyc(1, 4'b0001, 4'h2, 0);
    cyc(1, 4'b0010, 4'h4, 1);
    cyc(1, 4'b0000, 4'hE, 0);
    chk_all("pre_jump", 4'h2, 4'h4, 4'h0, 4'h3, 1'b0, 1'b0);
    cyc(1, 4'b1000, 4'hA, 1);
    chk_all("jump", 4'h2, 4'h4, 4'h0, 4'hA, 1'b1, 1'b0);
    cyc(1, 4'b0011, 4'h7, 0);
    chk_all("illegal", 4'h2, 4'h4, 4'h0, 4'hB, 1'b0, 1'b1);
    cyc(1, 4'b1100, 4'h1, 1);
    chk_all("illegal_pc", 4'h2, 4'h4, 4'h0, 4'hC, 1'b1, 1'b1);
    cyc(1, 4'b0000, 4'h0, 0);
    cyc(1, 4'b0001, 4'h6, 1);
    cyc(1, 4'b0010, 4'h8, 0);
    cyc(1, 4'b0100, 4'h9, 0);
    cyc(1, 4'b1000, 4'h3, 1);
    chk_all("sticky", 4'h6, 4'h8, 4'h9, 4'h3, 1'b1, 1'b1);
    pulse_reset();
    cyc(1, 4'b0001, 4'h9, 1);
    for (int i = 0; i < 5; i++) cyc(1, 4'b0000, 4'h1, 0);
    chk_all("pre_async", 4'h9, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0);
    step = 1'b1; ld = 4'b0001; alu_out = 4'hF; alu_c = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_all("rst_held", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1, 4'b0000, 4'h4, 0);
    chk_all("first_edge", 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, which is the data width of ALU result, registers and PC.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port step, input, 1, the instruction-cycle enable; state is held when step=0.
REQ-005 SHALL have port alu_out, input, WIDTH, the ALU sum result to be written back.
REQ-006 SHALL have port alu_c, input, 1, the ALU carry-out.
REQ-007 SHALL have port ld, input, 4, the one-hot write-select: [0]=A, [1]=B, [2]=output port, [3]=PC (jump).
REQ-008 SHALL have port a, output, WIDTH, the register A value, fed back to ALU ain.
REQ-009 SHALL have port b, output, WIDTH, the register B value, fed back to ALU bin.
REQ-010 SHALL have port port_out, output, WIDTH, the output-port register.
REQ-011 SHALL have port pc, output, WIDTH, the program counter.
REQ-012 SHALL have port cflag, output, 1, the carry flag latched from alu_c.
REQ-013 SHALL have port ld_err, output, 1, a sticky flag set by an illegal ld pattern.

Function
REQ-014 SHALL register all outputs; no output has a combinational path from any input.
REQ-015 SHALL, on a rising edge with step=1 and ld one-hot, write alu_out into the selected register, so the value is visible one cycle after the edge (latency 1).
REQ-016 SHALL, on a rising edge with step=1 and ld[3]=0, set pc to pc+1 modulo 2^WIDTH (wraps 4'hF to 4'h0).
REQ-017 SHALL, on a rising edge with step=1 and ld=4'b1000, set pc to alu_out instead of incrementing it.
REQ-018 SHALL, on every rising edge with step=1, set cflag to alu_c, independent of ld.
REQ-019 SHALL treat ld=4'b0000 with step=1 as a no-write cycle: pc increments, cflag updates, and A/B/port_out hold.
REQ-020 SHALL treat an ld with more than one bit set and step=1 as illegal: no A/B/port_out write, pc increments (no jump), cflag updates, and ld_err is set to 1.
REQ-021 SHALL hold ld_err at 1 until reset.
REQ-022 SHALL, with step=0, hold a, b, port_out, pc, cflag and ld_err unchanged regardless of ld, alu_out and alu_c.
REQ-023 SHALL make the write of a register visible to the ALU through a/b only in the cycle after the write edge; there is no bypass path.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force a, b, port_out and pc to 0, and cflag and ld_err to 0.
REQ-025 SHALL, on rst_n assertion mid-cycle, clear state immediately without waiting for clk, and discard any pending write.
REQ-026 SHALL make the first rising edge after rst_n deasserts a normal cycle; if step=1 on that edge, pc becomes 1.

Structure
REQ-027 SHALL take from shared package minicpu_pkg the nibble_t typedef (logic [WIDTH-1:0]) and the ld bit-index constants LD_A=0, LD_B=1, LD_OUT=2 and LD_PC=3.
REQ-028 SHALL implement A, B and port_out as three instances of sub-module nibble_reg (WIDTH-bit register with async active-low clear and load enable).
REQ-029 SHALL implement pc, cflag, ld_err and the ld legality decode locally in reg_bank.

Verification
REQ-030 SHALL be verified by: reset, then step=1, ld=0001, alu_out=4'h5, alu_c=0 for 1 edge -> a=5, b=0, pc=1, cflag=0.
REQ-031 SHALL be verified by: ld=0100, alu_out=4'hF, alu_c=1 -> port_out=F, cflag=1; then step=0 for 3 edges with alu_out=4'h3 -> all outputs unchanged.
REQ-032 SHALL be verified by: 16 edges with ld=0000 from reset -> pc steps 1..F then 0 (wrap).
REQ-033 SHALL be verified by: pc=3, ld=1000, alu_out=4'hA -> pc=A, with a, b and port_out unchanged.
REQ-034 SHALL be verified by: ld=0011, alu_out=4'h7 with a=2 and b=4 -> a=2, b=4, pc incremented, ld_err=1; ld_err stays 1 through 5 further legal cycles.
REQ-035 SHALL be verified by: rst_n pulsed low between clock edges with a=9 and pc=6 -> all outputs 0 before the next edge.
